// File: rtl/program_loader.sv
// Boot loader: framed byte stream -> big-endian 32-bit words written to instruction memory from word 0.
// Latency: every output is registered; one edge from the deciding accept (or start) to the visible effect.
// Backpressure: rx_ready is high only while a frame byte is expected and drops for the one-cycle memory write.
module program_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_e;

    // Largest legal word count is the full memory depth.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;
    localparam bit          TMO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_e                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             word_idx_q, word_idx_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [23:0]             shift_q, shift_d;
    logic [7:0]              xsum_q, xsum_d;
    logic [31:0]             tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [1:0]              err_code_q, err_code_d;
    logic                    rx_ready_q, rx_ready_d;
    logic                    we_q, we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    accept;

    // rx_ready_q is high exactly in the byte-receiving states, so it doubles as the handshake qualifier.
    assign accept = rx_valid & rx_ready_q;

    // Next-state logic: frame parsing, word assembly, checksum and idle timeout.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        xsum_d     = xsum_q;
        tmo_d      = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    xsum_d     = '0;
                    err_code_d = 2'd0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    xsum_d      = xsum_q ^ rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    xsum_d     = xsum_q ^ rx_data;
                    if ({1'b0, len_q[15:8], rx_data} > CAPACITY) begin
                        state_d    = S_ERROR;
                        err_code_d = 2'd1;
                    end else if ({len_q[15:8], rx_data} == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xsum_d     = xsum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Fourth byte goes straight into the write word; the shifter holds the first three.
                        wdata_d = {shift_q, rx_data};
                        addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        state_d = S_WRITE;
                    end else begin
                        shift_d = {shift_q[15:0], rx_data};
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_q == len_q - 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == xsum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = 2'd2;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle counter only runs while a byte is expected; any accept restarts it.
        if (rx_ready_q && !accept) begin
            tmo_d = tmo_q + 32'd1;
            if (TMO_EN && tmo_q == TMO_LAST) begin
                state_d    = S_ERROR;
                err_code_d = 2'd3;
            end
        end
    end

    // Output flags decoded from the next state so they appear registered, one edge after the cause.
    always_comb begin
        rx_ready_d = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
        we_d       = (state_d == S_WRITE);
        busy_d     = rx_ready_d | we_d;
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    // State and output registers; reset returns to IDLE with every output low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            xsum_q     <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            xsum_q     <= xsum_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cpu_run    = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level model predicts writes, final status and memory image.
// Each accepted byte's position in the frame decides the expected effect one edge later.
// A compare process checks status flags and every write strobe on each falling edge.
module tb_program_loader;

    localparam int AW  = 6;
    localparam int CAP = 64;
    localparam int TMO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          chk_en  = 1'b0;
    bit          start_noise = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_done  = 1'b0;
    logic        exp_error = 1'b0;
    logic [1:0]  exp_code  = 2'd0;
    logic [37:0] exp_wr[$];
    logic [31:0] frame_words[$];
    logic [31:0] mem_exp[CAP];
    logic [31:0] mem_obs[CAP];
    logic [37:0] cmp_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Status flags against the model every cycle; each write strobe against the predicted write list.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            check("cpu_run", 64'(cpu_run), 64'(exp_done));
            check("error", 64'(error), 64'(exp_error));
            check("err_code", 64'(err_code), 64'(exp_code));
            if (imem_we) begin
                check("write_expected", 64'(exp_wr.size() != 0), 64'(1));
                if (exp_wr.size() != 0) begin
                    cmp_e = exp_wr.pop_front();
                    check("wr_addr", 64'(imem_addr), 64'(cmp_e[37:32]));
                    check("wr_data", 64'(imem_wdata), 64'(cmp_e[31:0]));
                end
                mem_obs[imem_addr] = imem_wdata;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'(0));
        check({tag, "_imem_we"}, 64'(imem_we), 64'(0));
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'(0));
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
        check({tag, "_cpu_run"}, 64'(cpu_run), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
        check({tag, "_err_code"}, 64'(err_code), 64'(0));
    endtask

    // Called on a falling edge; a stray byte rides along with start and must not be taken.
    task automatic do_start();
        start    = 1'b1;
        rx_valid = 1'($urandom);
        rx_data  = 8'($urandom);
        @(posedge CLK);
        exp_busy  = 1'b1;
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_code  = 2'd0;
        @(negedge CLK);
        start    = 1'b0;
        rx_valid = 1'b0;
        check("start_rdy", 64'(rx_ready), 64'(1));
    endtask

    // Called on a falling edge; returns just after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int waited;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = start_noise ? ($urandom_range(3, 0) == 0) : 1'b0;
            @(negedge CLK);
        end
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (!rx_ready && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        ok = rx_ready;
        if (!ok) check("byte_accept_bound", 64'(rx_ready), 64'(1));
        else @(posedge CLK);
    endtask

    // abort_kind 1: stall at byte abort_at until timeout; 2: pulse reset there instead.
    task automatic run_frame(input logic [15:0] n, input int maxgap, input int csum_override,
                             input logic [7:0] csum_flip, input int abort_at, input int abort_kind);
        logic [7:0] fb[$];
        logic [7:0] x;
        logic [7:0] cs;
        bit         ok;
        int         cut;
        int         last_we;
        int         bad;
        fb.push_back(n[15:8]);
        fb.push_back(n[7:0]);
        if (n <= CAP)
            for (int w = 0; w < int'(n); w++)
                for (int b = 3; b >= 0; b--) fb.push_back(frame_words[w][8*b +: 8]);
        x = 8'd0;
        foreach (fb[i]) x ^= fb[i];
        cs = (csum_override >= 0) ? 8'(csum_override) : (x ^ csum_flip);
        fb.push_back(cs);
        cut = (abort_at >= 0) ? abort_at : fb.size();
        if (n <= CAP)
            for (int w = 0; w < int'(n); w++)
                if (2 + 4 * w + 3 < cut) begin
                    exp_wr.push_back({6'(w), frame_words[w]});
                    mem_exp[w] = frame_words[w];
                end
        last_we = -1;
        do_start();
        for (int p = 0; p < fb.size(); p++) begin
            if (p == cut) break;
            send_byte(fb[p], $urandom_range(maxgap, 0), ok);
            if (!ok) begin
                rx_valid = 1'b0;
                return;
            end
            if (p == 1 && n > CAP) begin
                exp_busy = 1'b0; exp_error = 1'b1; exp_code = 2'd1;
                @(negedge CLK);
                rx_valid = 1'b0;
                check("overflow_rdy", 64'(rx_ready), 64'(0));
                break;
            end else if (p == fb.size() - 1) begin
                exp_busy = 1'b0;
                if (cs == x) exp_done = 1'b1;
                else begin exp_error = 1'b1; exp_code = 2'd2; end
                @(negedge CLK);
                rx_valid = 1'b0;
                check("csum_rdy", 64'(rx_ready), 64'(0));
            end else if (p >= 2 && (p - 2) % 4 == 3) begin
                @(negedge CLK);
                check("we_latency", 64'(imem_we), 64'(1));
                check("write_rdy", 64'(rx_ready), 64'(0));
                if (maxgap == 0 && last_we >= 0) check("word_period", 64'(cyc - last_we), 64'(5));
                last_we = cyc;
            end else begin
                @(negedge CLK);
                check("rdy_after_accept", 64'(rx_ready), 64'(1));
            end
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        if (cut < fb.size()) begin
            if (abort_kind == 1) begin
                repeat (TMO - 1) @(posedge CLK);
                @(posedge CLK);
                exp_busy = 1'b0; exp_error = 1'b1; exp_code = 2'd3;
                @(negedge CLK);
                check("timeout_code", 64'(err_code), 64'(3));
            end else begin
                #2 RST = 1'b0;
                exp_busy = 1'b0; exp_done = 1'b0; exp_error = 1'b0; exp_code = 2'd0;
                #1 check_all_zero("midrst");
                @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
            end
        end
        check("writes_all_seen", 64'(exp_wr.size()), 64'(0));
        bad = 0;
        for (int i = 0; i < CAP; i++) if (mem_obs[i] !== mem_exp[i]) bad++;
        check("mem_image", 64'(bad), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] n;
        for (int i = 0; i < CAP; i++) begin
            mem_exp[i] = 32'd0;
            mem_obs[i] = 32'd0;
        end
        #1 RST = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge CLK);
        check_all_zero("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Directed N=2 load with hand-computed checksum 0x57.
        frame_words = '{32'h20080005, 32'h01095020};
        run_frame(16'd2, 0, 8'h57, 8'h00, -1, 0);
        check("t1_done", 64'(done), 64'(1));
        check("t1_cpu_run", 64'(cpu_run), 64'(1));
        check("t1_err_code", 64'(err_code), 64'(0));
        check("t1_word0", 64'(mem_obs[0]), 64'h20080005);
        check("t1_word1", 64'(mem_obs[1]), 64'h01095020);

        // Empty image.
        run_frame(16'd0, 0, 8'h00, 8'h00, -1, 0);
        check("n0_done", 64'(done), 64'(1));

        // One word past capacity.
        run_frame(16'd65, 0, -1, 8'h00, -1, 0);
        check("ovf_error", 64'(error), 64'(1));
        check("ovf_code", 64'(err_code), 64'(1));
        check("ovf_cpu_run", 64'(cpu_run), 64'(0));

        // Checksum off by one bit (correct would be 0x09).
        frame_words = '{32'h12345678};
        run_frame(16'd1, 0, 8'h08, 8'h00, -1, 0);
        check("csum_error", 64'(error), 64'(1));
        check("csum_code", 64'(err_code), 64'(2));
        check("csum_word0", 64'(mem_obs[0]), 64'h12345678);

        // Stall after three data bytes.
        frame_words = '{$urandom, $urandom};
        run_frame(16'd2, 2, -1, 8'h00, 5, 1);
        check("tmo_cpu_run", 64'(cpu_run), 64'(0));

        // N=4 back-to-back, then the same image with random gaps and ignored start pulses.
        frame_words = '{$urandom, $urandom, $urandom, $urandom};
        run_frame(16'd4, 0, -1, 8'h00, -1, 0);
        for (int i = 0; i < 4; i++) mem_obs[i] = 32'd0;
        start_noise = 1'b1;
        run_frame(16'd4, 4, -1, 8'h00, -1, 0);
        check("gap_done", 64'(done), 64'(1));

        // Reset during DATA, one word already written.
        frame_words = '{$urandom, $urandom, $urandom, $urandom};
        run_frame(16'd4, 3, -1, 8'h00, 8, 2);

        // Full-capacity image.
        start_noise = 1'b0;
        frame_words.delete();
        for (int i = 0; i < CAP; i++) frame_words.push_back($urandom);
        run_frame(16'(CAP), 0, -1, 8'h00, -1, 0);
        check("full_done", 64'(done), 64'(1));

        // Random frames: sizes, gaps, occasional corrupt checksum or oversize length.
        start_noise = 1'b1;
        for (int f = 0; f < 14; f++) begin
            n = ($urandom_range(7, 0) == 0) ? 16'($urandom_range(70, 65)) : 16'($urandom_range(10, 1));
            frame_words.delete();
            for (int i = 0; i < int'(n) && i < CAP; i++) frame_words.push_back($urandom);
            run_frame(n, $urandom_range(5, 0), -1,
                      ($urandom_range(4, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
